// File: rtl/rv32i_wb_data_responder.sv
// rv32i_wb_data_responder
//
// Wishbone pipelined-mode responder for the rv32i data bus. Accepted requests
// go into a 2-entry in-order queue. Each entry that reaches the head waits
// LATENCY cycles and is then executed: a byte-lane-masked write into the
// internal word array, or a full-word read. Every executed request produces a
// single-cycle registered ack.
//
// Optional feature macro: RV32I_WB_ERR_EN
//   When defined, the o_wb_err output exists. Out-of-range requests then
//   terminate with o_wb_err instead of o_wb_ack, with the same timing.
//   When undefined, out-of-range requests ack normally: a read returns 0 and
//   a write is dropped.
//
// Parameters
//   DEPTH    memory size in 32-bit words (power of two)
//   LATENCY  wait cycles between reaching the queue head and the ack (0..15)
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_wb_cyc        bus cycle; low flushes all queued requests
//   i_wb_stb        request strobe
//   i_wb_we         1 = write, 0 = read
//   i_wb_addr       byte address
//   i_wb_data       lane-aligned write data
//   i_wb_sel        byte enables
//   o_wb_ack        one-cycle completion pulse
//   o_wb_stall      queue full; strobe not accepted
//   o_wb_data       read word, valid with o_wb_ack on a read
//   o_wb_err        (RV32I_WB_ERR_EN only) out-of-range termination

module rv32i_wb_data_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
`ifdef RV32I_WB_ERR_EN
    output logic        o_wb_err,
`endif
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [3:0]  LAT4 = 4'(LATENCY);

    // Queue storage (not reset; only slots covered by r_count are meaningful)
    logic          r_q_we   [2];
    logic [AW-1:0] r_q_idx  [2];
    logic [31:0]   r_q_data [2];
    logic [3:0]    r_q_sel  [2];
    logic          r_q_inr  [2];

    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [3:0]  r_wait;
    logic        r_ack;
    logic [31:0] r_rdata;
`ifdef RV32I_WB_ERR_EN
    logic        r_err;
`endif

    logic [31:0] r_mem [DEPTH];

    logic          w_stall;
    logic          w_push;
    logic          w_exec;
    logic          w_load;
    logic [1:0]    w_count_nxt;
    logic          w_req_inr;
    logic          w_head_we;
    logic [AW-1:0] w_head_idx;
    logic [31:0]   w_head_data;
    logic [3:0]    w_head_sel;
    logic          w_head_inr;
    logic [31:0]   w_head_word;
    logic          w_unused_addr_lo;

    // Byte offset bits play no part in a word-wide memory
    assign w_unused_addr_lo = ^i_wb_addr[1:0];

    assign w_stall   = (r_count == 2'd2);
    assign w_push    = i_wb_cyc && i_wb_stb && !w_stall;
    assign w_req_inr = (i_wb_addr[31:AW+2] == '0);

    assign w_head_we   = r_q_we[r_rd_ptr];
    assign w_head_idx  = r_q_idx[r_rd_ptr];
    assign w_head_data = r_q_data[r_rd_ptr];
    assign w_head_sel  = r_q_sel[r_rd_ptr];
    assign w_head_inr  = r_q_inr[r_rd_ptr];
    assign w_head_word = r_mem[w_head_idx];

    // Head executes once its wait counter has run out
    assign w_exec      = (r_count != 2'd0) && (r_wait == 4'd0);
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_exec);

    // A fresh entry becomes head when the queue was empty or the old head pops
    assign w_load = (w_count_nxt != 2'd0) && ((r_count == 2'd0) || w_exec);

    // Queue bookkeeping and wait counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_wait   <= 4'd0;
        end else if (!i_wb_cyc) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_wait   <= 4'd0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_exec) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_load) begin
                r_wait <= LAT4;
            end else if (r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end
        end
    end

    // Queue entry capture
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_we[r_wr_ptr]   <= i_wb_we;
            r_q_idx[r_wr_ptr]  <= i_wb_addr[AW+1:2];
            r_q_data[r_wr_ptr] <= i_wb_data;
            r_q_sel[r_wr_ptr]  <= i_wb_sel;
            r_q_inr[r_wr_ptr]  <= w_req_inr;
        end
    end

    // Memory write; a write already executing at an abort edge still lands
    always_ff @(posedge i_clk) begin
        if (w_exec && w_head_we && w_head_inr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_head_sel[b]) begin
                    r_mem[w_head_idx][8*b +: 8] <= w_head_data[8*b +: 8];
                end
            end
        end
    end

    // Registered termination outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
`ifdef RV32I_WB_ERR_EN
            r_err   <= 1'b0;
`endif
        end else if (!i_wb_cyc || !w_exec) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
`ifdef RV32I_WB_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
`ifdef RV32I_WB_ERR_EN
            r_ack   <= w_head_inr;
            r_err   <= !w_head_inr;
`else
            r_ack   <= 1'b1;
`endif
            r_rdata <= (!w_head_we && w_head_inr) ? w_head_word : 32'd0;
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_stall = w_stall;
    assign o_wb_data  = r_rdata;
`ifdef RV32I_WB_ERR_EN
    assign o_wb_err   = r_err;
`endif

endmodule
